card_dealer: RTL and testbench

//  Requester side of the RNG next_int/rand_int interface.
//  On each deal request, pulses next_int to the RNG and samples rand_int after a fixed latency.

---
 rtl/card_dealer.sv | 158 +++++++++++++++
 tb/tb_card_dealer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: requester side of the RNG next_int/rand_int handshake.
// Deals cards 1..DECK_SIZE without replacement. Values that are out of range
// or already dealt are redrawn. After MAX_RETRY consecutive rejections the
// dealer scans the dealt bitmap linearly, which keeps deal latency bounded.
//
// Ports
//   i_clock        system clock, all logic on posedge
//   i_reset_n      synchronous active-low reset
//   i_deal_req     request one card (sampled only in IDLE)
//   i_shuffle      return all cards to the deck, aborts a deal in progress
//   i_rand_int     RNG output value
//   o_next_int     one-cycle pulse asking the RNG for a new value
//   o_card         last dealt card, held until the next deal
//   o_card_valid   one-cycle pulse, o_card updated this cycle
//   o_busy         high in every state except IDLE
//   o_deck_empty   high when no cards are left
//   o_cards_left   number of undealt cards
//
// state | meaning
// IDLE  | waiting for a deal request
// PULSE | o_next_int high for this single cycle
// WAIT  | RNG latency; o_next_int held low
// CHECK | sample i_rand_int, accept or retry
// SCAN  | linear search of the bitmap for the first free card
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int RNG_LAT   = 2,
    parameter int MAX_RETRY = 8
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_deal_req,
    input  logic        i_shuffle,
    input  logic [15:0] i_rand_int,
    output logic        o_next_int,
    output logic [5:0]  o_card,
    output logic        o_card_valid,
    output logic        o_busy,
    output logic        o_deck_empty,
    output logic [5:0]  o_cards_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_CHECK,
        S_SCAN
    } state_t;

    localparam logic [5:0]  DECK_N     = 6'(DECK_SIZE);
    localparam logic [15:0] DECK_MAX   = 16'(DECK_SIZE);
    localparam logic [7:0]  LAT_LOAD   = 8'(RNG_LAT - 1);
    localparam logic [7:0]  RETRY_LAST = 8'(MAX_RETRY - 1);

    state_t      r_state;
    // Sized to the full 6-bit card space; bits above DECK_SIZE are never set.
    logic [63:0] r_dealt;
    logic [5:0]  r_cards_left;
    logic [5:0]  r_card;
    logic        r_card_valid;
    logic        r_next_int;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_retry;
    logic [5:0]  r_idx;

    logic        w_in_range;
    logic [5:0]  w_rand_idx;
    logic        w_accept;

    // Any set bit in [15:6] makes the value exceed DECK_MAX, so the full-width
    // compare covers the upper bits as well.
    assign w_in_range = (i_rand_int != 16'd0) && (i_rand_int <= DECK_MAX);
    assign w_rand_idx = i_rand_int[5:0] - 6'd1;
    assign w_accept   = w_in_range && !r_dealt[w_rand_idx];

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_dealt      <= '0;
            r_cards_left <= DECK_N;
            r_card       <= '0;
            r_card_valid <= 1'b0;
            r_next_int   <= 1'b0;
            r_wait_cnt   <= '0;
            r_retry      <= '0;
            r_idx        <= '0;
        end else begin
            r_card_valid <= 1'b0;
            r_next_int   <= 1'b0;
            if (i_shuffle) begin
                // Takes priority over any accept in the same cycle.
                r_dealt      <= '0;
                r_cards_left <= DECK_N;
                r_state      <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_deal_req && (r_cards_left != 6'd0)) begin
                            r_state    <= S_PULSE;
                            r_next_int <= 1'b1;
                            r_retry    <= '0;
                        end
                    end
                    S_PULSE: begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= LAT_LOAD;
                    end
                    S_WAIT: begin
                        if (r_wait_cnt == 8'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 8'd1;
                        end
                    end
                    S_CHECK: begin
                        if (w_accept) begin
                            r_dealt[w_rand_idx] <= 1'b1;
                            r_card              <= i_rand_int[5:0];
                            r_card_valid        <= 1'b1;
                            r_cards_left        <= r_cards_left - 6'd1;
                            r_state             <= S_IDLE;
                        end else if (r_retry == RETRY_LAST) begin
                            r_retry <= r_retry + 8'd1;
                            r_idx   <= '0;
                            r_state <= S_SCAN;
                        end else begin
                            r_retry    <= r_retry + 8'd1;
                            r_next_int <= 1'b1;
                            r_state    <= S_PULSE;
                        end
                    end
                    S_SCAN: begin
                        // cards_left > 0 on entry, so a free bit is always found.
                        if (!r_dealt[r_idx]) begin
                            r_dealt[r_idx] <= 1'b1;
                            r_card         <= r_idx + 6'd1;
                            r_card_valid   <= 1'b1;
                            r_cards_left   <= r_cards_left - 6'd1;
                            r_state        <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_next_int   = r_next_int;
    assign o_card       = r_card;
    assign o_card_valid = r_card_valid;
    assign o_busy       = (r_state != S_IDLE);
    assign o_deck_empty = (r_cards_left == 6'd0);
    assign o_cards_left = r_cards_left;

endmodule

// File: tb/tb_card_dealer.sv
// Testbench for card_dealer: RNG model driven from a value queue, expected
// cards held in a scoreboard queue and compared when o_card_valid pulses.
module tb_card_dealer;

    localparam int DECK = 52;
    localparam int LAT  = 2;
    localparam int MAXR = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        deal_req = 1'b0;
    logic        shuffle  = 1'b0;
    logic [15:0] rand_int = 16'd0;
    logic        next_int;
    logic [5:0]  card;
    logic        card_valid;
    logic        busy;
    logic        deck_empty;
    logic [5:0]  cards_left;

    card_dealer #(.DECK_SIZE(DECK), .RNG_LAT(LAT), .MAX_RETRY(MAXR)) u_dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_deal_req   (deal_req),
        .i_shuffle    (shuffle),
        .i_rand_int   (rand_int),
        .o_next_int   (next_int),
        .o_card       (card),
        .o_card_valid (card_valid),
        .o_busy       (busy),
        .o_deck_empty (deck_empty),
        .o_cards_left (cards_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int rng_q[$];
    int stuck_val = 1;
    int pulses = 0;
    int first_pulse_cyc = -1;
    int valid_cyc = 0;
    bit got_valid = 1'b0;
    bit prev_ni = 1'b0;
    int seen[64];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // RNG model and output monitor.
    always @(negedge clk) begin
        if (next_int) begin
            chk("next_int_gap", int'(prev_ni), 0);
            pulses++;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            if (rng_q.size() > 0) rand_int = 16'(rng_q.pop_front());
            else                  rand_int = 16'(stuck_val);
        end
        prev_ni = next_int;
        if (card_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                chk("card", int'(card), exp_q.pop_front());
            end
            chk("busy_at_valid", int'(busy), 0);
            seen[card]++;
            valid_cyc = cyc;
            got_valid = 1'b1;
        end
    end

    task automatic deal(input int exp_card, input int exp_pulses, input int exp_lat);
        int c0;
        @(negedge clk);
        pulses = 0;
        first_pulse_cyc = -1;
        got_valid = 1'b0;
        exp_q.push_back(exp_card);
        c0 = cyc;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        for (int i = 0; i < 300 && !got_valid; i++) @(negedge clk);
        if (!got_valid) begin
            chk("deal_timeout", 0, 1);
            exp_q.delete();
        end else begin
            chk("latency", valid_cyc - c0, exp_lat);
            chk("first_pulse", first_pulse_cyc - c0, 1);
        end
        repeat (3) @(negedge clk);
        chk("pulses", pulses, exp_pulses);
    endtask

    task automatic do_shuffle();
        @(negedge clk);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int busy_seen;
        int uniq;
        foreach (seen[i]) seen[i] = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_card", int'(card), 0);
        chk("rst_valid", int'(card_valid), 0);
        chk("rst_next_int", int'(next_int), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cards_left", int'(cards_left), DECK);
        chk("rst_deck_empty", int'(deck_empty), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First-try accept
        rng_q.push_back(17);
        deal(17, 1, LAT + 3);
        chk("left_after_1", int'(cards_left), 51);

        // Duplicate then accept
        rng_q.push_back(17);
        rng_q.push_back(23);
        deal(23, 2, 1 + 2 * (LAT + 2));
        chk("left_after_2", int'(cards_left), 50);

        // Zero, too large, upper bits set, then accept
        rng_q.push_back(0);
        rng_q.push_back(53);
        rng_q.push_back(16'hFFFF);
        rng_q.push_back(5);
        deal(5, 4, 1 + 4 * (LAT + 2));
        chk("left_after_3", int'(cards_left), 49);

        // RNG stuck at 1: retries exhausted, SCAN finds card 2
        rng_q.push_back(1);
        deal(1, 1, LAT + 3);
        stuck_val = 1;
        deal(2, MAXR, 1 + MAXR * (LAT + 2) + 2);
        chk("left_after_scan", int'(cards_left), 47);

        // Shuffle in the CHECK cycle of an accepting draw
        rng_q.push_back(9);
        @(negedge clk);
        pulses = 0;
        c0 = cyc;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_check", int'(busy), 1);
        chk("cyc_in_check", cyc - c0, 4);
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        chk("shuf_valid", int'(card_valid), 0);
        chk("shuf_busy", int'(busy), 0);
        chk("shuf_left", int'(cards_left), DECK);
        chk("shuf_card", int'(card), 2);
        repeat (3) @(negedge clk);
        chk("shuf_pulses", pulses, 1);

        // Full deck with a permuting RNG
        foreach (seen[i]) seen[i] = 0;
        for (int i = 0; i < DECK; i++) begin
            rng_q.push_back(((i * 7) % DECK) + 1);
            deal(((i * 7) % DECK) + 1, 1, LAT + 3);
        end
        uniq = 0;
        for (int v = 1; v <= DECK; v++) if (seen[v] == 1) uniq++;
        chk("perm_unique", uniq, DECK);
        chk("deck_empty", int'(deck_empty), 1);
        chk("left_empty", int'(cards_left), 0);

        // Deal request on an empty deck is ignored
        @(negedge clk);
        pulses = 0;
        busy_seen = 0;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_seen = 1;
            @(negedge clk);
        end
        chk("empty_busy", busy_seen, 0);
        chk("empty_pulses", pulses, 0);

        // Reset during WAIT
        do_shuffle();
        rng_q.push_back(11);
        deal(11, 1, LAT + 3);
        rng_q.push_back(3);
        @(negedge clk);
        c0 = cyc;
        deal_req = 1'b1;
        @(negedge clk);
        deal_req = 1'b0;
        @(negedge clk);
        chk("busy_in_wait", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_card", int'(card), 0);
        chk("mid_rst_valid", int'(card_valid), 0);
        chk("mid_rst_next_int", int'(next_int), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_left", int'(cards_left), DECK);
        chk("mid_rst_empty", int'(deck_empty), 0);
        rst_n = 1'b1;
        rng_q.delete();
        repeat (6) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
